mlaccel_compute_macc: RTL

MLACCEL_COMPUTE_MACC -- requirements
Module: mlaccel_compute_macc

---
 rtl/mlaccel_compute_macc_pkg.sv | 17 +
 rtl/mlaccel_compute_mul_lane.sv | 28 ++
 rtl/mlaccel_compute_macc.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mlaccel_compute_macc_pkg.sv
// Shared constants for the lane-parallel multiply-accumulate block:
// operation codes and default geometry.
package mlaccel_compute_macc_pkg;

  // Operation codes carried with every accepted op.
  typedef enum logic [1:0] {
    OP_MAC      = 2'b00,  // acc += a*b
    OP_SET      = 2'b01,  // acc  = a*b
    OP_FLUSH    = 2'b10,  // emit acc, then acc = 0 (operands ignored)
    OP_MACFLUSH = 2'b11   // acc += a*b, emit, then acc = 0
  } op_e;

  localparam int DEF_SZ      = 8;   // parallel 8-bit lanes
  localparam int DEF_MUL_LAT = 3;   // multiply pipeline depth (>= 1)
  localparam int DEF_ACC_W   = 24;  // signed accumulator width (>= 17)

endpackage

// File: rtl/mlaccel_compute_mul_lane.sv
// One lane of the signed 8x8->16 multiplier, MUL_LAT register stages deep.
// All stages advance together under a shared clock enable so that the
// product stays aligned with the op sideband pipelined in the parent.
module mlaccel_compute_mul_lane #(
  parameter int MUL_LAT = 3
) (
  input  logic               clock,
  input  logic               en,
  input  logic signed [7:0]  a,
  input  logic signed [7:0]  b,
  output logic signed [15:0] prod
);

  logic signed [15:0] stage_q [MUL_LAT];

  // Multiply into the first stage, then shift the product down the pipe.
  always_ff @(posedge clock) begin
    if (en) begin
      stage_q[0] <= 16'(a) * 16'(b);
      for (int k = 1; k < MUL_LAT; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign prod = stage_q[MUL_LAT-1];

endmodule

// File: rtl/mlaccel_compute_macc.sv
// Lane-parallel signed multiply-accumulate engine.
//
// Handshake: an op transfers on the rising edge where in_valid && in_ready;
// a result transfers on the rising edge where out_valid && out_ready.
// The whole pipeline (multiplier stages, sideband, accumulators, output
// register) advances only when the output register is empty or being
// drained, and in_ready is exactly that advance condition, so no op is
// ever dropped and results leave strictly in acceptance order.
module mlaccel_compute_macc
  import mlaccel_compute_macc_pkg::*;
#(
  parameter int SZ      = DEF_SZ,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic              clock,
  input  logic              reset,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [SZ*8-1:0]   in_a,
  input  logic [SZ*8-1:0]   in_b,
  input  logic [3:0]        in_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SZ*16-1:0]  out_data
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  logic               adv;
  logic [MUL_LAT-1:0] v_q;
  op_e                op_q [MUL_LAT];
  logic [3:0]         sh_q [MUL_LAT];
  logic               last_v;
  op_e                last_op;
  logic [3:0]         last_sh;
  logic               last_flush;

  logic signed [15:0]      prod    [SZ];
  logic signed [ACC_W-1:0] acc_q   [SZ];
  logic signed [ACC_W-1:0] acc_nxt [SZ];
  logic        [15:0]      emit    [SZ];

  assign adv        = !out_valid || out_ready;
  // During reset nothing can be lost, so the input side reads as ready.
  assign in_ready   = adv || reset;
  assign busy       = out_valid || (|v_q);
  assign last_v     = v_q[MUL_LAT-1];
  assign last_op    = op_q[MUL_LAT-1];
  assign last_sh    = sh_q[MUL_LAT-1];
  assign last_flush = (last_op == OP_FLUSH) || (last_op == OP_MACFLUSH);

  // Stage valids: cleared by reset, shifted in lock-step with the lanes.
  always_ff @(posedge clock) begin
    if (reset) begin
      v_q <= '0;
    end else if (adv) begin
      v_q[0] <= in_valid;
      for (int k = 1; k < MUL_LAT; k++) begin
        v_q[k] <= v_q[k-1];
      end
    end
  end

  // Op and shift sideband, qualified by the stage valids.
  always_ff @(posedge clock) begin
    if (adv) begin
      op_q[0] <= op_e'(in_op);
      sh_q[0] <= in_shift;
      for (int k = 1; k < MUL_LAT; k++) begin
        op_q[k] <= op_q[k-1];
        sh_q[k] <= sh_q[k-1];
      end
    end
  end

  for (genvar i = 0; i < SZ; i++) begin : g_lane
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] pre;
    logic signed [ACC_W-1:0] shifted;

    mlaccel_compute_mul_lane #(.MUL_LAT(MUL_LAT)) u_mul (
      .clock (clock),
      .en    (adv),
      .a     (in_a[8*i +: 8]),
      .b     (in_b[8*i +: 8]),
      .prod  (prod[i])
    );

    // Sign-extend the product; the sum wraps naturally at ACC_W bits.
    assign prod_ext   = ACC_W'(prod[i]);
    assign sum        = acc_q[i] + prod_ext;
    assign acc_nxt[i] = (last_op == OP_MAC) ? sum :
                        (last_op == OP_SET) ? prod_ext : '0;
    assign pre        = (last_op == OP_MACFLUSH) ? sum : acc_q[i];
    assign shifted    = pre >>> last_sh;
    assign emit[i]    = (shifted > SAT_MAX) ? 16'h7fff :
                        (shifted < SAT_MIN) ? 16'h8000 : shifted[15:0];
  end

  // Accumulators update when a valid op leaves the last stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SZ; i++) acc_q[i] <= '0;
    end else if (adv && last_v) begin
      for (int i = 0; i < SZ; i++) acc_q[i] <= acc_nxt[i];
    end
  end

  // Output register: loaded by a flush leaving the pipe, held while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= last_v && last_flush;
      if (last_v && last_flush) begin
        for (int i = 0; i < SZ; i++) out_data[16*i +: 16] <= emit[i];
      end
    end
  end

endmodule
